onchip_memory_loader: RTL and testbench

- Upstream write engine for the 32-bit single-port on-chip memory (14-bit word address, 4-bit byteenable).
- Accepts a byte stream, e.g. from a UART boot receiver, and packs it little-endian into 32-bit words.
- Issues single-cycle writes to the memory slave port starting at a programmed word address.
- Holds the CPU in reset for the whole load, so firmware is in place before the CPU fetches.

---
 rtl/onchip_memory_loader_pkg.sv | 15 +
 rtl/onchip_memory_loader_if.sv | 25 ++
 rtl/onchip_memory_loader_byte_word_packer.sv | 39 +++
 rtl/onchip_memory_loader.sv | 124 ++++++++++++
 tb/tb_onchip_memory_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_memory_loader_pkg.sv
// Shared types and defaults for the on-chip memory loader.
package onchip_memory_loader_pkg;
    localparam int ADDR_W_DEF     = 14;
    localparam int DEPTH_DEF      = 16384;
    localparam int CNT_W_DEF      = 17;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } loader_state_t;
endpackage

// File: rtl/onchip_memory_loader_if.sv
// Byte-stream input and memory write port of the loader, bundled as one interface.
import onchip_memory_loader_pkg::*;

interface onchip_memory_loader_if #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                        s_valid;
    logic [7:0]                  s_data;
    logic                        s_ready;
    logic [ADDR_W-1:0]           m_address;
    logic [BYTES_PER_WORD-1:0]   m_byteenable;
    logic                        m_chipselect;
    logic                        m_write;
    logic [8*BYTES_PER_WORD-1:0] m_writedata;

    // master = the loader; slave = byte producer plus memory
    modport master (
        input  s_valid, s_data,
        output s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata
    );
    modport slave (
        output s_valid, s_data,
        input  s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata
    );
endinterface

// File: rtl/onchip_memory_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into one word and tracks which lanes are filled.
import onchip_memory_loader_pkg::*;

module onchip_memory_loader_byte_word_packer (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_accept,
    input  logic                           i_flush,
    input  logic                           i_clear,
    input  logic [7:0]                     i_data,
    output logic [BYTES_PER_WORD-1:0][7:0] o_word,
    output logic [BYTES_PER_WORD-1:0]      o_mask,
    output logic                           o_word_ready
);
    logic [LANE_W-1:0]              r_lane_cnt;
    logic [BYTES_PER_WORD-1:0][7:0] r_word;
    logic [BYTES_PER_WORD-1:0]      r_mask;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_lane_cnt <= '0;
            r_word     <= '0;
            r_mask     <= '0;
        end else if (i_accept) begin
            r_lane_cnt <= r_lane_cnt + 1'b1;
            for (int l = 0; l < BYTES_PER_WORD; l++) begin
                if (r_lane_cnt == LANE_W'(l)) begin
                    r_word[l] <= i_data;
                    r_mask[l] <= 1'b1;
                end
            end
        end
    end

    // Word completes on the byte that fills the top lane, or on the last byte of the load
    assign o_word_ready = i_accept && ((r_lane_cnt == LANE_W'(BYTES_PER_WORD - 1)) || i_flush);
    assign o_word       = r_word;
    assign o_mask       = r_mask;
endmodule

// File: rtl/onchip_memory_loader.sv
// Streams bytes into on-chip memory from a base word address while holding the CPU in reset.
import onchip_memory_loader_pkg::*;

module onchip_memory_loader #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [CNT_W-1:0]      i_byte_count,
    onchip_memory_loader_if.master bus,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int               SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(DEPTH * BYTES_PER_WORD);

    loader_state_t                  r_state;
    logic [ADDR_W-1:0]              r_addr;
    logic [CNT_W-1:0]               r_rem;
    logic                           r_s_ready;
    logic                           r_wr;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_error;
    logic [SUM_W-1:0]               w_end;
    logic                           w_accept;
    logic                           w_word_ready;
    logic [BYTES_PER_WORD-1:0][7:0] w_word;
    logic [BYTES_PER_WORD-1:0]      w_mask;

    // End of the requested region in bytes; wide enough that it cannot overflow
    assign w_end    = SUM_W'({i_base_addr, {LANE_W{1'b0}}}) + SUM_W'(i_byte_count);
    assign w_accept = r_s_ready && bus.s_valid;

    onchip_memory_loader_byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_accept     (w_accept),
        .i_flush      (r_rem == CNT_W'(1)),
        .i_clear      (r_wr),
        .i_data       (bus.s_data),
        .o_word       (w_word),
        .o_mask       (w_mask),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_s_ready <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr  <= i_base_addr;
                        r_rem   <= i_byte_count;
                        r_error <= 1'b0;
                        if (w_end > LIMIT) begin
                            r_error <= 1'b1;
                        end else if (i_byte_count == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_COLLECT;
                            r_busy    <= 1'b1;
                            r_s_ready <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_rem <= r_rem - 1'b1;
                        if (w_word_ready) begin
                            r_state   <= S_WRITE;
                            r_s_ready <= 1'b0;
                            r_wr      <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_wr   <= 1'b0;
                    r_addr <= r_addr + 1'b1;
                    if (r_rem == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_COLLECT;
                        r_s_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready      = r_s_ready;
    assign bus.m_chipselect = r_wr;
    assign bus.m_write      = r_wr;
    assign bus.m_address    = r_addr;
    assign bus.m_byteenable = r_wr ? w_mask : '0;
    assign bus.m_writedata  = r_wr ? w_word : '0;
    assign o_cpu_hold       = r_busy;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
endmodule

// File: tb/tb_onchip_memory_loader.sv
// Directed bench for onchip_memory_loader: loads, tails, range errors, backpressure, reset.
module tb_onchip_memory_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [13:0] i_base_addr;
    logic [16:0] i_byte_count;
    logic        o_cpu_hold, o_busy, o_done, o_error;

    onchip_memory_loader_if #(.ADDR_W(14)) bus ();

    onchip_memory_loader #(.ADDR_W(14), .DEPTH(16384), .CNT_W(17)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_byte_count (i_byte_count),
        .bus          (bus.master),
        .o_cpu_hold   (o_cpu_hold),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Write/done monitor, sampled on the falling edge
    logic [13:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wb[$];
    int          wc[$];
    int cyc = 0, done_n = 0, done_cyc = 0, rdy_viol = 0, hold_viol = 0, cs_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.m_write === 1'b1) begin
            wa.push_back(bus.m_address);
            wd.push_back(bus.m_writedata);
            wb.push_back(bus.m_byteenable);
            wc.push_back(cyc);
            if (bus.s_ready !== 1'b0) rdy_viol++;
        end
        if (bus.m_chipselect !== bus.m_write || (bus.m_write !== 1'b1 && bus.m_byteenable !== 4'h0))
            cs_viol++;
        if (o_cpu_hold !== o_busy) hold_viol++;
        if (o_done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    logic [7:0] src[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [13:0] b, input logic [16:0] n);
        i_base_addr  = b;
        i_byte_count = n;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Feed src until done, until stop_after bytes are accepted, or until budget runs out
    task automatic stream(input bit rnd, input int stop_after, input bit spur, input int budget);
        int idx = 0;
        int c = 0;
        int d0 = done_n;
        bit acc;
        while (done_n == d0 && idx < stop_after && c < budget) begin
            bus.s_valid = (idx < src.size()) && (!rnd || ($urandom_range(0, 2) != 0));
            bus.s_data  = bus.s_valid ? src[idx] : 8'h00;
            i_start = spur && (c == 2);
            if (i_start) begin
                i_base_addr  = 14'h3000;
                i_byte_count = 17'd0;
            end
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            tick();
            if (acc) idx++;
            c++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        i_start     = 1'b0;
        n_chk++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d of %0d bytes after %0d cycles", idx, src.size(), c);
        end
    endtask

    task automatic test_reset();
        logic [56:0] outs;
        reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_byte_count = '0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00;
        repeat (2) tick();
        @(negedge clk);
        outs = {bus.s_ready, bus.m_chipselect, bus.m_write, bus.m_byteenable, bus.m_address,
                bus.m_writedata, o_cpu_hold, o_busy, o_done, o_error};
        n_chk++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_aligned();
        int w0 = wa.size(), d0 = done_n, h0 = hold_viol;
        src.delete();
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        start_load(14'h0010, 17'd8);
        @(negedge clk);
        n_chk++;
        if ({o_busy, o_cpu_hold} !== 2'b11) begin n_fail++; $display("FAIL aligned_busy: got %b want 11", {o_busy, o_cpu_hold}); end
        tick();
        stream(1'b0, 1000, 1'b0, 200);
        n_chk++;
        if (wa.size() - w0 != 2) begin n_fail++; $display("FAIL aligned_count: got %0d want 2", wa.size() - w0); end
        else begin
            n_chk++;
            if ({wa[w0], wd[w0], wb[w0]} !== {14'h0010, 32'h04030201, 4'hF}) begin
                n_fail++; $display("FAIL aligned_w0: got %h/%h/%h want 0010/04030201/f", wa[w0], wd[w0], wb[w0]);
            end
            n_chk++;
            if ({wa[w0+1], wd[w0+1], wb[w0+1]} !== {14'h0011, 32'h08070605, 4'hF}) begin
                n_fail++; $display("FAIL aligned_w1: got %h/%h/%h want 0011/08070605/f", wa[w0+1], wd[w0+1], wb[w0+1]);
            end
            n_chk++;
            if (done_n - d0 != 1 || done_cyc != wc[w0+1] + 1) begin
                n_fail++; $display("FAIL aligned_done: %0d pulses at cycle %0d, want 1 at %0d", done_n - d0, done_cyc, wc[w0+1] + 1);
            end
        end
        n_chk++;
        if (hold_viol != h0) begin n_fail++; $display("FAIL aligned_hold: cpu_hold differed from busy %0d times, want 0", hold_viol - h0); end
    endtask

    task automatic test_partial();
        int w0 = wa.size();
        src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        start_load(14'h0000, 17'd6);
        stream(1'b0, 1000, 1'b0, 200);
        n_chk++;
        if (wa.size() - w0 != 2) begin n_fail++; $display("FAIL partial_count: got %0d want 2", wa.size() - w0); end
        else begin
            n_chk++;
            if ({wa[w0], wd[w0], wb[w0]} !== {14'h0000, 32'hDDCCBBAA, 4'hF}) begin
                n_fail++; $display("FAIL partial_w0: got %h/%h/%h want 0000/ddccbbaa/f", wa[w0], wd[w0], wb[w0]);
            end
            n_chk++;
            if ({wa[w0+1], wd[w0+1], wb[w0+1]} !== {14'h0001, 32'h0000FFEE, 4'h3}) begin
                n_fail++; $display("FAIL partial_tail: got %h/%h/%h want 0001/0000ffee/3", wa[w0+1], wd[w0+1], wb[w0+1]);
            end
        end
    endtask

    task automatic test_range_error();
        int w0 = wa.size(), d0 = done_n;
        start_load(14'h3FFF, 17'd5);
        @(negedge clk);
        n_chk++;
        if ({o_error, o_busy, bus.s_ready} !== 3'b100) begin
            n_fail++; $display("FAIL range_flags: err/busy/rdy got %b want 100", {o_error, o_busy, bus.s_ready});
        end
        repeat (3) tick();
        @(negedge clk);
        n_chk++;
        if (wa.size() != w0 || o_error !== 1'b1) begin
            n_fail++; $display("FAIL range_sticky: writes %0d err %b want 0 and 1", wa.size() - w0, o_error);
        end
        tick();
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(14'h3FFF, 17'd4);
        @(negedge clk);
        n_chk++;
        if ({o_error, o_busy} !== 2'b01) begin n_fail++; $display("FAIL range_clear: err/busy got %b want 01", {o_error, o_busy}); end
        tick();
        stream(1'b0, 1000, 1'b0, 200);
        n_chk++;
        if (wa.size() - w0 != 1 || done_n - d0 != 1) begin
            n_fail++; $display("FAIL top_word_count: writes %0d done %0d want 1 and 1", wa.size() - w0, done_n - d0);
        end else begin
            n_chk++;
            if ({wa[w0], wd[w0], wb[w0]} !== {14'h3FFF, 32'h44332211, 4'hF}) begin
                n_fail++; $display("FAIL top_word: got %h/%h/%h want 3fff/44332211/f", wa[w0], wd[w0], wb[w0]);
            end
        end
    endtask

    task automatic test_zero_length();
        int w0 = wa.size();
        start_load(14'h0200, 17'd0);
        @(negedge clk);
        n_chk++;
        if ({o_busy, o_done, o_cpu_hold} !== 3'b111) begin
            n_fail++; $display("FAIL zero_first: busy/done/hold got %b want 111", {o_busy, o_done, o_cpu_hold});
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({o_busy, o_done, o_cpu_hold} !== 3'b000 || wa.size() != w0) begin
            n_fail++; $display("FAIL zero_second: busy/done/hold got %b writes %0d want 000 and 0", {o_busy, o_done, o_cpu_hold}, wa.size() - w0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int w0 = wa.size(), r0 = rdy_viol, c0 = cs_viol;
        src.delete();
        for (int i = 0; i < 40; i++) src.push_back(8'(i * 37 + 5));
        start_load(14'h0100, 17'd40);
        stream(1'b1, 1000, 1'b0, 2000);
        n_chk++;
        if (wa.size() - w0 != 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", wa.size() - w0); end
        else begin
            for (int i = 0; i < 10; i++) begin
                n_chk++;
                if ({wa[w0+i], wd[w0+i], wb[w0+i]} !== {14'(14'h0100 + i), src[4*i+3], src[4*i+2], src[4*i+1], src[4*i], 4'hF}) begin
                    n_fail++; $display("FAIL bp_word%0d: got %h/%h/%h want %h/%h%h%h%h/f", i, wa[w0+i], wd[w0+i], wb[w0+i],
                                       14'(14'h0100 + i), src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]);
                end
            end
        end
        n_chk++;
        if (rdy_viol != r0 || cs_viol != c0) begin
            n_fail++; $display("FAIL bp_strobes: s_ready in write %0d, strobe misuse %0d, want 0 and 0", rdy_viol - r0, cs_viol - c0);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [56:0] outs;
        int w0 = wa.size(), d0;
        src.delete();
        for (int i = 0; i < 12; i++) src.push_back(8'(8'hC0 + i));
        start_load(14'h0040, 17'd12);
        stream(1'b0, 3, 1'b0, 100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outs = {bus.s_ready, bus.m_chipselect, bus.m_write, bus.m_byteenable, bus.m_address,
                bus.m_writedata, o_cpu_hold, o_busy, o_done, o_error};
        n_chk++;
        if (outs !== '0 || wa.size() != w0) begin
            n_fail++; $display("FAIL midload_reset: outputs %h writes %0d want 0 and 0", outs, wa.size() - w0);
        end
        reset = 1'b0;
        repeat (2) tick();
        d0 = done_n;
        src = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
        start_load(14'h0020, 17'd4);
        stream(1'b0, 1000, 1'b1, 200);
        repeat (4) tick();
        @(negedge clk);
        n_chk++;
        if (wa.size() - w0 != 1 || done_n - d0 != 1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reload_count: writes %0d done %0d busy %b want 1 1 0", wa.size() - w0, done_n - d0, o_busy);
        end else begin
            n_chk++;
            if ({wa[w0], wd[w0], wb[w0]} !== {14'h0020, 32'h5D5C5B5A, 4'hF}) begin
                n_fail++; $display("FAIL reload_word: got %h/%h/%h want 0020/5d5c5b5a/f", wa[w0], wd[w0], wb[w0]);
            end
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned();
        test_partial();
        test_range_error();
        test_zero_length();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
